remote_comm: RTL and testbench

Host-side command transmitter and response receiver for the Knight's Tour robot link. It takes a 16-bit command and sends it over an 8N1 UART line as two bytes, high byte first. It also receives 1-byte responses (0xA5 = positive acknowledge) from the robot. It sits between the bench or host controller and the robot's UART `RX`/`TX` pins.

---
 rtl/remote_comm.sv | 159 +++++++++++++++
 tb/tb_remote_comm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - 16-bit command transmitter (two 8N1 bytes, high first) and 8N1 response receiver
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} cmd_state_t;

  cmd_state_t state, state_nxt;
  logic [15:0] cmd_q;
  logic        accept;
  logic        tx_start;
  logic [7:0]  tx_byte;

  logic          tx_busy;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          tx_done;

  assign tx_done = tx_busy && (tx_bit == 4'd9) && (tx_baud == BAUD_LAST);

  // The transmitter is already idle on the first SEND_LO cycle, which
  // gives exactly one idle-high clock between the two bytes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tx_start  = 1'b0;
    tx_byte   = cmd_q[7:0];
    case (state)
      IDLE: begin
        if (snd_cmd) begin
          accept    = 1'b1;
          tx_start  = 1'b1;
          tx_byte   = cmd[15:8];
          state_nxt = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_done) state_nxt = SEND_LO;
      end
      SEND_LO: begin
        if (!tx_busy)     tx_start  = 1'b1;
        else if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd_q   <= 16'h0000;
      cmd_snt <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q   <= cmd;
        cmd_snt <= 1'b0;
      end
      if (state == SEND_LO && tx_done) cmd_snt <= 1'b1;
    end
  end

  // tx_shift holds the remaining data bits followed by the stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bit   <= 4'd0;
      tx_shift <= '1;
      TX       <= 1'b1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_baud  <= '0;
      tx_bit   <= 4'd0;
      tx_shift <= {1'b1, tx_byte};
      TX       <= 1'b0;
    end else if (tx_busy) begin
      if (tx_baud == BAUD_LAST) begin
        tx_baud <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          TX      <= 1'b1;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          TX       <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  logic          rx_ff1, rx_ff2, rx_prev;
  logic          rx_busy;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_sample;
  logic          start_edge;

  assign rx_sample  = rx_busy && (rx_baud == ((rx_bit == 4'd0) ? HALF_LAST : BAUD_LAST));
  assign start_edge = !rx_busy && rx_prev && !rx_ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1   <= 1'b1;
      rx_ff2   <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_bit   <= 4'd0;
      rx_shift <= 8'h00;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
      if (start_edge) begin
        rx_busy  <= 1'b1;
        rx_baud  <= '0;
        rx_bit   <= 4'd0;
        resp_rdy <= 1'b0;
      end else if (rx_sample) begin
        rx_baud <= '0;
        rx_bit  <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          // Line already back high at the start-bit centre: treat as noise
          if (rx_ff2) rx_busy <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_busy  <= 1'b0;
          resp     <= rx_shift;
          resp_rdy <= 1'b1;
        end else begin
          rx_shift <= {rx_ff2, rx_shift[7:1]};
        end
      end else if (rx_busy) begin
        rx_baud <= rx_baud + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - scoreboard bench for remote_comm: decodes TX frames and checks received responses
module tb_remote_comm;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        RX;
  logic        TX, cmd_snt, resp_rdy;
  logic [7:0]  resp;

  assign RX = loop_en ? TX : rx_drv;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .cmd(cmd), .snd_cmd(snd_cmd),
    .TX(TX), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] resp_exp[$];
  bit tx_check_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_cmd(input logic [15:0] value);
    cmd = value;
    snd_cmd = 1'b1;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
  endtask

  task automatic wait_cmd_snt(input string name);
    int n = 0;
    while (cmd_snt !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: cmd_snt not seen after %0d clocks, expected within 322", name, n);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (BD) @(posedge clk);
      #1;
    end
  endtask

  // TX monitor: sample each bit at its centre and score the decoded byte
  initial begin : tx_mon
    logic [7:0] b;
    logic s0, s9;
    forever begin
      @(negedge clk);
      if (TX === 1'b0) begin
        repeat (BD / 2 - 1) @(negedge clk);
        s0 = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BD) @(negedge clk);
        s9 = TX;
        if (tx_check_en) begin
          check("tx_start_bit", {31'd0, s0}, 32'd0);
          check("tx_stop_bit", {31'd0, s9}, 32'd1);
          if (tx_exp.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL tx_unexpected_byte: got 0x%0h, expected no frame", b);
          end else begin
            check("tx_byte", {24'd0, b}, {24'd0, tx_exp.pop_front()});
          end
        end
      end
    end
  end

  // Response monitor: score every rising edge of resp_rdy
  initial begin : resp_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_rdy === 1'b1 && !prev) begin
        if (resp_exp.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL resp_unexpected: got 0x%0h, expected no response", resp);
        end else begin
          check("resp_byte", {24'd0, resp}, {24'd0, resp_exp.pop_front()});
        end
      end
      prev = (resp_rdy === 1'b1);
    end
  end

  initial begin : main
    int n;
    repeat (3) @(posedge clk); #1;
    check("reset_tx", {31'd0, TX}, 32'd1);
    check("reset_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    check("reset_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check("reset_resp", {24'd0, resp}, 32'h00);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // single command 0x4004, with a busy-time retry of 0xFFFF
    tx_exp.push_back(8'h40);
    tx_exp.push_back(8'h04);
    pulse_cmd(16'h4004);
    check("tx_start_latency", {31'd0, TX}, 32'd0);
    n = 0;
    while (cmd_snt !== 1'b1 && n < 400) begin
      if (n == 50) begin
        cmd = 16'hFFFF;
        snd_cmd = 1'b1;
      end else begin
        snd_cmd = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (n == 10 * BD) check("gap_idle_high", {31'd0, TX}, 32'd1);
      if (n == 10 * BD + 1) check("lo_start_bit", {31'd0, TX}, 32'd0);
    end
    snd_cmd = 1'b0;
    vectors++;
    if (n < 20 * BD || n > 20 * BD + 2) begin
      errors++;
      $display("FAIL cmd_snt_latency: got %0d clocks, expected %0d..%0d", n, 20 * BD, 20 * BD + 2);
    end
    repeat (50) @(posedge clk); #1;
    check("cmd_snt_hold", {31'd0, cmd_snt}, 32'd1);

    // loopback 0x2A5C
    loop_en = 1'b1;
    tx_exp.push_back(8'h2A);
    tx_exp.push_back(8'h5C);
    resp_exp.push_back(8'h2A);
    resp_exp.push_back(8'h5C);
    pulse_cmd(16'h2A5C);
    check("cmd_snt_cleared", {31'd0, cmd_snt}, 32'd0);
    wait_cmd_snt("loop_cmd_snt");
    repeat (40) @(posedge clk); #1;
    check("loop_resp", {24'd0, resp}, 32'h5C);
    check("loop_resp_rdy", {31'd0, resp_rdy}, 32'd1);
    loop_en = 1'b0;
    repeat (10) @(posedge clk); #1;

    // external ACK
    resp_exp.push_back(8'hA5);
    send_rx(8'hA5);
    check("ack_resp", {24'd0, resp}, 32'hA5);
    check("ack_resp_rdy", {31'd0, resp_rdy}, 32'd1);
    repeat (30) @(posedge clk); #1;
    check("ack_rdy_hold", {31'd0, resp_rdy}, 32'd1);

    // 3-clock glitch: its start edge clears resp_rdy, no new byte
    rx_drv = 1'b0;
    repeat (3) @(posedge clk); #1;
    rx_drv = 1'b1;
    check("rdy_clear_on_start", {31'd0, resp_rdy}, 32'd0);
    repeat (40) @(posedge clk); #1;
    check("glitch_no_rdy", {31'd0, resp_rdy}, 32'd0);
    check("glitch_resp_kept", {24'd0, resp}, 32'hA5);

    // reset during the high byte of 0x1234
    tx_check_en = 1'b0;
    pulse_cmd(16'h1234);
    repeat (BD + 4) @(posedge clk); #1;
    check("pre_reset_tx_bit0", {31'd0, TX}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    check("rst_resp", {24'd0, resp}, 32'h00);
    check("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    rst = 1'b0;
    repeat (200) @(posedge clk); #1;
    check("rst_tx_idle", {31'd0, TX}, 32'd1);

    check("tx_bytes_outstanding", tx_exp.size(), 32'd0);
    check("resp_bytes_outstanding", resp_exp.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
